// File: rtl/neuron_pkg.sv
// Shared definitions for the neuron multiply-accumulate slice.
//   DATA_W_DEF : default width of activations, weights and the saturated sum
//   SAT_MAX    : largest representable output value at the default width
//   state_t    : neuron evaluation states (IDLE / ACCUM / DONE)
package neuron_pkg;

  localparam int unsigned DATA_W_DEF = 4;
  localparam logic [DATA_W_DEF-1:0] SAT_MAX = '1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } state_t;

endpackage

// File: rtl/neuron_mac_sat_clip.sv
// Combinational saturation of the wide accumulator to the output width.
//   i_acc : full-precision accumulator (ACC_W bits, unsigned)
//   o_sum : i_acc clipped to 2^DATA_W-1
//   o_sat : 1 when i_acc exceeds 2^DATA_W-1
module sat_clip #(
  parameter int unsigned ACC_W  = 11,
  parameter int unsigned DATA_W = 4
) (
  input  logic [ACC_W-1:0]  i_acc,
  output logic [DATA_W-1:0] o_sum,
  output logic              o_sat
);

  // Any set bit above the output width means the value does not fit.
  assign o_sat = |i_acc[ACC_W-1:DATA_W];
  assign o_sum = o_sat ? '1 : i_acc[DATA_W-1:0];

endmodule

// File: rtl/neuron_mac.sv
// Weighted-sum neuron: accepts N_INPUTS (activation, weight) beats, sums the
// products without wrap, then presents the saturated sum until taken.
//   clk, rst_n         : clock, async active-low reset
//   clr                : synchronous abort, drops any partial/complete result
//   in_valid/in_ready  : input beat handshake, in_data/in_weight unsigned
//   out_valid/out_ready: result handshake, out_sum saturated, out_sat overflow
module neuron_mac
  import neuron_pkg::*;
#(
  parameter int unsigned N_INPUTS = 4,
  parameter int unsigned DATA_W   = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [DATA_W-1:0] in_weight,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_sum,
  output logic              out_sat
);

  localparam int unsigned CNT_W = $clog2(N_INPUTS + 1);
  localparam int unsigned ACC_W = 2 * DATA_W + CNT_W;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(N_INPUTS);

  state_t                r_state, w_state_nxt;
  logic [ACC_W-1:0]      r_acc,   w_acc_nxt;
  logic [CNT_W-1:0]      r_cnt,   w_cnt_nxt;
  logic [CNT_W-1:0]      w_cnt_inc;
  logic [2*DATA_W-1:0]   w_prod;
  logic                  w_xfer;
  logic [DATA_W-1:0]     w_clip_sum;
  logic                  w_clip_sat;

  assign in_ready  = (r_state != DONE);
  assign out_valid = (r_state == DONE);
  assign w_xfer    = in_valid && in_ready;
  assign w_cnt_inc = r_cnt + CNT_W'(1);
  assign w_prod    = {{DATA_W{1'b0}}, in_data} * {{DATA_W{1'b0}}, in_weight};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_acc   <= '0;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_acc   <= w_acc_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_acc_nxt   = r_acc;
    w_cnt_nxt   = r_cnt;
    if (clr) begin
      w_state_nxt = IDLE;
      w_acc_nxt   = '0;
      w_cnt_nxt   = '0;
    end else begin
      case (r_state)
        IDLE, ACCUM: begin
          // IDLE and ACCUM share the accumulate path; IDLE holds a zero
          // accumulator, so N_INPUTS=1 goes straight to DONE.
          if (w_xfer) begin
            w_acc_nxt   = r_acc + ACC_W'(w_prod);
            w_cnt_nxt   = w_cnt_inc;
            w_state_nxt = (w_cnt_inc == CNT_LAST) ? DONE : ACCUM;
          end
        end
        DONE: begin
          if (out_ready) begin
            w_state_nxt = IDLE;
            w_acc_nxt   = '0;
            w_cnt_nxt   = '0;
          end
        end
        default: begin
          w_state_nxt = IDLE;
          w_acc_nxt   = '0;
          w_cnt_nxt   = '0;
        end
      endcase
    end
  end

  sat_clip #(
    .ACC_W  (ACC_W),
    .DATA_W (DATA_W)
  ) u_sat_clip (
    .i_acc (r_acc),
    .o_sum (w_clip_sum),
    .o_sat (w_clip_sat)
  );

  // The accumulator is non-zero during ACCUM, so outputs are gated to 0
  // outside DONE.
  assign out_sum = out_valid ? w_clip_sum : '0;
  assign out_sat = out_valid && w_clip_sat;

endmodule

// File: tb/tb_neuron_mac.sv
module tb_neuron_mac;
  import neuron_pkg::*;

  localparam int N  = 4;
  localparam int DW = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          clr = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [DW-1:0] in_data = '0;
  logic [DW-1:0] in_weight = '0;
  logic          out_valid;
  logic          out_ready = 1'b1;
  logic [DW-1:0] out_sum;
  logic          out_sat;

  int errors = 0;
  int checks = 0;

  // Behavioural reference: running sum of products, beat count, result flag.
  int m_sum = 0;
  int m_cnt = 0;
  bit m_done = 1'b0;

  neuron_mac #(.N_INPUTS(N), .DATA_W(DW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .clr       (clr),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_weight (in_weight),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sum   (out_sum),
    .out_sat   (out_sat)
  );

  always #5 clk = ~clk;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_sum <= 0; m_cnt <= 0; m_done <= 1'b0;
    end else if (clr) begin
      m_sum <= 0; m_cnt <= 0; m_done <= 1'b0;
    end else if (m_done) begin
      if (out_ready) begin
        m_sum <= 0; m_cnt <= 0; m_done <= 1'b0;
      end
    end else if (in_valid) begin
      m_sum <= m_sum + int'(in_data) * int'(in_weight);
      m_cnt <= m_cnt + 1;
      if (m_cnt + 1 == N) m_done <= 1'b1;
    end
  end

  // Per-cycle compare of all outputs against the reference.
  always @(negedge clk) begin
    if (rst_n) begin
      int exp_sum;
      int exp_sat;
      int exp_rdy;
      int exp_vld;
      exp_vld = m_done ? 1 : 0;
      exp_rdy = m_done ? 0 : 1;
      exp_sat = (m_done && m_sum > int'(SAT_MAX)) ? 1 : 0;
      exp_sum = !m_done ? 0 : (m_sum > int'(SAT_MAX) ? int'(SAT_MAX) : m_sum);
      checks++;
      if (int'(in_ready) != exp_rdy || int'(out_valid) != exp_vld ||
          int'(out_sum) != exp_sum || int'(out_sat) != exp_sat) begin
        errors++;
        $display("FAIL model t=%0t: got rdy=%0d vld=%0d sum=%0d sat=%0d expected rdy=%0d vld=%0d sum=%0d sat=%0d",
                 $time, in_ready, out_valid, out_sum, out_sat, exp_rdy, exp_vld, exp_sum, exp_sat);
      end
    end
  end

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic drive(input bit v, input int d, input int w);
    @(negedge clk);
    #1;
    in_valid  = v;
    in_data   = DW'(d);
    in_weight = DW'(w);
  endtask

  // Call directly after the last beat is driven: result must be visible at
  // the very next sample point.
  task automatic expect_result(input string nm, input int s, input int sat);
    @(negedge clk);
    chk({nm, "_valid"}, int'(out_valid), 1);
    chk({nm, "_sum"}, int'(out_sum), s);
    chk({nm, "_sat"}, int'(out_sat), sat);
  endtask

  initial begin
    int pat[7];
    pat = '{1, 0, 0, 1, 1, 0, 1};

    #12;
    @(negedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("reset_ready", int'(in_ready), 1);
    chk("reset_valid", int'(out_valid), 0);
    chk("reset_sum", int'(out_sum), 0);

    // Basic sum 1+4+3+0 = 8
    drive(1, 1, 1); drive(1, 2, 2); drive(1, 1, 3); drive(1, 0, 5);
    expect_result("basic", 8, 0);
    drive(0, 0, 0);
    // 4 x 225 = 900 saturates
    repeat (4) drive(1, 15, 15);
    expect_result("max", 15, 1);
    drive(0, 0, 0);
    repeat (4) drive(1, 3, 5);
    expect_result("sixty", 15, 1);
    drive(0, 0, 0);
    // 3+4+8+0 = 15 exactly, no saturation
    drive(1, 1, 3); drive(1, 1, 4); drive(1, 2, 4); drive(1, 0, 9);
    expect_result("edge15", 15, 0);
    drive(0, 0, 0);

    // Backpressure: result held, beats ignored
    out_ready = 1'b0;
    drive(1, 1, 1); drive(1, 2, 2); drive(1, 1, 3); drive(1, 0, 5);
    expect_result("hold", 8, 0);
    for (int i = 0; i < 5; i++) begin
      #1;
      in_valid  = 1'b1;
      in_data   = DW'($urandom_range(0, 15));
      in_weight = DW'($urandom_range(0, 15));
      @(negedge clk);
      chk("hold_valid", int'(out_valid), 1);
      chk("hold_sum", int'(out_sum), 8);
      chk("hold_ready", int'(in_ready), 0);
    end
    #1 out_ready = 1'b1; in_valid = 1'b0;
    @(negedge clk);
    chk("release_valid", int'(out_valid), 0);

    // Bubbles: 4 accepted beats of 2*2 = 16 -> saturates
    foreach (pat[i]) drive(pat[i] != 0, 2, 2);
    expect_result("bubble", 15, 1);
    drive(0, 0, 0);

    // Reset mid-accumulation
    drive(1, 1, 1); drive(1, 1, 1);
    @(negedge clk);
    #1 in_valid = 1'b0; rst_n = 1'b0;
    @(negedge clk);
    chk("rst_mid_valid", int'(out_valid), 0);
    chk("rst_mid_ready", int'(in_ready), 1);
    #1 rst_n = 1'b1;
    repeat (4) drive(1, 1, 1);
    expect_result("after_rst", 4, 0);
    drive(0, 0, 0);

    // clr mid-accumulation
    drive(1, 1, 1); drive(1, 1, 1);
    @(negedge clk);
    #1 in_valid = 1'b0; clr = 1'b1;
    @(negedge clk);
    #1 clr = 1'b0;
    repeat (4) drive(1, 1, 1);
    expect_result("after_clr", 4, 0);
    drive(0, 0, 0);

    // clr in DONE discards the result
    out_ready = 1'b0;
    repeat (4) drive(1, 1, 1);
    expect_result("done_clr_pre", 4, 0);
    #1 in_valid = 1'b0; clr = 1'b1;
    @(negedge clk);
    chk("done_clr_valid", int'(out_valid), 0);
    chk("done_clr_sum", int'(out_sum), 0);
    #1 clr = 1'b0; out_ready = 1'b1;

    // Randomized traffic, checked cycle by cycle against the reference
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      #1;
      in_valid  = ($urandom_range(0, 3) != 0);
      in_data   = DW'($urandom_range(0, 15));
      in_weight = ($urandom_range(0, 1) != 0) ? DW'($urandom_range(0, 3)) : DW'($urandom_range(0, 15));
      out_ready = ($urandom_range(0, 1) != 0);
      clr       = ($urandom_range(0, 40) == 0);
      rst_n     = ($urandom_range(0, 499) != 0);
    end
    @(negedge clk);
    #1 rst_n = 1'b1; clr = 1'b0; in_valid = 1'b0;
    repeat (3) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/neuron_mac.md
NEURON_MAC -- requirements
Module: neuron_mac

Interface
REQ-001 Parameter N_INPUTS, default 4, number of weighted inputs per neuron evaluation (legal 1..16).
REQ-002 Parameter DATA_W, default 4, width of input activations, weights and output sum.
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 rst_n  input  1  reset, asynchronous assert and active-low.
REQ-005 clr  input  1  synchronous abort; discards any partial accumulation.
REQ-006 in_valid  input  1  in_data/in_weight hold a valid beat.
REQ-007 in_ready  output  1  block accepts a beat this cycle.
REQ-008 in_data  input  DATA_W  unsigned activation.
REQ-009 in_weight  input  DATA_W  unsigned weight.
REQ-010 out_valid  output  1  out_sum/out_sat hold a completed neuron result.
REQ-011 out_ready  input  1  downstream threshold stage accepts the result.
REQ-012 out_sum  output  DATA_W  saturated weighted sum; drives the downstream compare stage's test operand.
REQ-013 out_sat  output  1  the full-precision sum exceeded 2^DATA_W-1.

Function
REQ-014 A beat transfers when in_valid and in_ready are both high at a rising edge.
REQ-015 Each transferred beat adds in_data*in_weight (2*DATA_W bits, unsigned) to an internal accumulator of width ACC_W = 2*DATA_W + clog2(N_INPUTS+1); the accumulator never wraps.
REQ-016 FSM states: IDLE, ACCUM, DONE.
REQ-017 IDLE: accumulator zero, beat counter zero, in_ready=1, out_valid=0; first transfer -> ACCUM, or -> DONE if N_INPUTS=1.
REQ-018 ACCUM: in_ready=1; each transfer increments the counter; the transfer that makes the count equal N_INPUTS -> DONE.
REQ-019 in_valid low in IDLE/ACCUM is a bubble: no state, counter or accumulator change.
REQ-020 DONE: in_ready=0, out_valid=1; out_sum = accumulator if accumulator <= 2^DATA_W-1, else 2^DATA_W-1; out_sat = 1 only in the latter case.
REQ-021 Latency: out_valid rises on the cycle after the edge that accepted the N_INPUTS-th beat.
REQ-022 DONE with out_ready=1 at an edge -> IDLE, accumulator and counter cleared; out_valid falls the following cycle; out_sum/out_sat hold stable while out_valid=1 and out_ready=0.
REQ-023 No input beat is accepted on the DONE->IDLE edge (in_ready is 0 in DONE); back-to-back results are spaced by at least N_INPUTS+1 cycles.
REQ-024 clr=1 at an edge forces IDLE with accumulator and counter cleared from any state, including DONE with out_valid=1 (result discarded); clr takes priority over a simultaneous in or out transfer.
REQ-025 out_sum and out_sat are 0 whenever out_valid=0.

Reset
REQ-026 rst_n low immediately forces IDLE, accumulator=0, counter=0, out_valid=0, out_sum=0, out_sat=0, in_ready=1 after release.
REQ-027 Reset mid-accumulation or in DONE discards all partial and completed results; the first beat after release starts a fresh neuron.

Structure
REQ-028 Shared package neuron_pkg holds DATA_W default, the state typedef (IDLE/ACCUM/DONE) and the saturation max constant.
REQ-029 One sub-module, sat_clip, performs the ACC_W -> DATA_W saturation and out_sat generation combinationally; the multiply-add stays in neuron_mac.

Verification
REQ-030 N_INPUTS=4, beats (1,1),(2,2),(1,3),(0,5) with out_ready=1 -> out_valid one cycle after 4th beat, out_sum=8, out_sat=0.
REQ-031 Beats (15,15) x4 -> out_sum=15, out_sat=1 (full sum 900, no wrap).
REQ-032 Beats (3,5) x4 -> sum 60 -> out_sum=15, out_sat=1; beats (1,3),(1,4),(2,4),(0,9) -> out_sum=15, out_sat=0 (boundary exactly 15).
REQ-033 Result ready, out_ready held low 5 cycles -> out_valid=1 and out_sum stable for 5 cycles, in_ready=0, in_valid beats ignored; out_ready high -> IDLE next cycle.
REQ-034 Bubbles: in_valid toggled 1,0,0,1,1,0,1 over beats (2,2) x4 -> out_sum=15, out_sat=1 (16), exactly 4 beats counted.
REQ-035 rst_n pulsed low after 2 of 4 beats, then 4 beats (1,1) -> out_sum=4; repeat with clr instead of rst_n -> same result, clr in DONE suppresses out_valid next cycle.
